// File: rtl/somador_if.sv
// ----------------------------------------------------------------------------
// somador_if
// Operand/result bundle for the registered adder.
//   entrada1, entrada2 : operands A and B (unsigned or two's complement)
//   resultado          : registered A+B, modulo 2^WIDTH
//   carry              : registered carry-out of bit WIDTH-1
//   overflow           : registered signed overflow
//   zero               : high when the registered resultado is zero
// Modports: master drives the operands and reads the results;
// slave (the adder) reads the operands and drives the results.
// ----------------------------------------------------------------------------
interface somador_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] entrada1;
    logic [WIDTH-1:0] entrada2;
    logic [WIDTH-1:0] resultado;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output entrada1, entrada2,
        input  resultado, carry, overflow, zero
    );

    modport slave (
        input  entrada1, entrada2,
        output resultado, carry, overflow, zero
    );
endinterface

// File: rtl/somador.sv
// ----------------------------------------------------------------------------
// somador
// Registered two-operand integer adder with carry, signed-overflow and zero
// flags. One result per cycle, one cycle of latency, no handshake.
//   clock   : system clock, state updates on the rising edge
//   reset_n : asynchronous active-low reset; forces resultado=0, carry=0,
//             overflow=0, zero=1 immediately
//   bus     : somador_if slave modport (operands in, registered results out)
// WIDTH must be at least 2.
// ----------------------------------------------------------------------------
module somador #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset_n,
    somador_if.slave  bus
);
    logic [WIDTH:0]   sum_d;
    logic             ovf_d;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             ovf_q;

    // Full WIDTH+1 bit sum; the top bit is the unsigned carry-out.
    assign sum_d = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};

    // Signed overflow: operands agree in sign but the sum's sign differs.
    assign ovf_d = (bus.entrada1[WIDTH-1] == bus.entrada2[WIDTH-1]) &&
                   (sum_d[WIDTH-1] != bus.entrada1[WIDTH-1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= sum_d[WIDTH-1:0];
            carry_q <= sum_d[WIDTH];
            ovf_q   <= ovf_d;
        end
    end

    assign bus.resultado = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    // Decoded from the register, so it reads 1 in reset and never sees the
    // live operands.
    assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_somador.sv
module tb_somador;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t last;

    somador_if #(.WIDTH(W)) bus ();

    somador #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference model using wide integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t    e;
        longint  us;
        longint  ss;
        longint  sa;
        longint  sb;
        longint  maxv;
        us   = longint'({32'h0, a}) + longint'({32'h0, b});
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ss   = sa + sb;
        maxv = (longint'(1) << (W - 1));
        e.r  = us[W-1:0];
        e.c  = us[W];
        e.o  = (ss > maxv - 1) || (ss < -maxv);
        e.z  = (us[W-1:0] == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input exp_t e);
        checks++;
        assert ({bus.resultado, bus.carry, bus.overflow, bus.zero} === {e.r, e.c, e.o, e.z})
        else begin
            errors++;
            $error("FAIL %s: got r=%h c=%b o=%b z=%b, want r=%h c=%b o=%b z=%b",
                   tag, bus.resultado, bus.carry, bus.overflow, bus.zero,
                   e.r, e.c, e.o, e.z);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.entrada1 = a;
        bus.entrada2 = b;
        q.push_back(model(a, b));
    endtask

    task automatic check_next(input string tag);
        @(posedge clock);
        #1;
        checks++;
        assert (q.size() > 0)
        else begin
            errors++;
            $error("FAIL %s: scoreboard empty, got r=%h want an entry", tag, bus.resultado);
        end
        if (q.size() > 0) begin
            last = q.pop_front();
            chk(tag, last);
        end
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        e = '{r: '0, c: 1'b0, o: 1'b0, z: 1'b1};
        chk(tag, e);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.entrada1 = '0;
        bus.entrada2 = '0;
        #1;
        check_reset("reset_initial");
        @(posedge clock);
        #1;
        check_reset("reset_held_over_edge");

        @(negedge clock);
        reset_n = 1'b1;

        send(32'h1, 32'h3);                 check_next("basic_1p3");
        send(32'hFFFF_FFFF, 32'h1);         check_next("unsigned_wrap");
        send(32'h7FFF_FFFF, 32'h1);         check_next("signed_ovf_pos");
        send(32'h8000_0000, 32'h8000_0000); check_next("signed_ovf_neg");
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF); check_next("neg1_plus_neg1");

        // Back-to-back pairs, one per cycle.
        send(32'd5, 32'd7);                 check_next("b2b_5p7");
        send(32'd100, 32'd200);             check_next("b2b_100p200");
        send(32'hFFFF_FFFE, 32'd2);         check_next("b2b_wrap");

        // Operand changes between edges must not disturb the outputs.
        send(32'd9, 32'd6);                 check_next("hold_base");
        #2;
        bus.entrada1 = 32'h1234_5678;
        bus.entrada2 = 32'h0BAD_F00D;
        #1;
        chk("hold_between_edges", last);
        q.push_back(model(bus.entrada1, bus.entrada2));
        check_next("late_operands_taken");

        // Mid-operation reset: pending (10,20) is discarded.
        send(32'd10, 32'd20);
        #2;
        reset_n = 1'b0;
        void'(q.pop_front());
        #1;
        check_reset("async_reset_no_edge");
        @(posedge clock);
        #1;
        check_reset("reset_discards_30");
        @(negedge clock);
        reset_n      = 1'b1;
        bus.entrada1 = 32'd1;
        bus.entrada2 = 32'd1;
        q.push_back(model(32'd1, 32'd1));
        check_next("post_reset_1p1");

        // Random pairs.
        for (int i = 0; i < 10; i++) begin
            send($urandom, $urandom);
            check_next("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
